// File: rtl/nn_pkg.sv
// nn_pkg: ALU opcodes and sequencer state encoding shared by the neuron datapath.
// Rev 1.0
`default_nettype none

package nn_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_MUL  = 3'b001;
  localparam logic [2:0] ALU_SGE  = 3'b010;
  localparam logic [2:0] ALU_PASS = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_MUL   = 3'd2,
    ST_ACC   = 3'd3,
    ST_ACT   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/neuron_alu_sequencer.sv
// neuron_alu_sequencer: drives a shared ALU through MAC over N pairs, then threshold.
// Rev 1.0
`default_nettype none

module neuron_alu_sequencer
  import nn_pkg::*;
#(
  parameter int nBits      = 32,
  parameter int MAX_INPUTS = 16,
  parameter int IDX_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IDX_W:0]     num_inputs,
  input  logic [nBits-1:0]   threshold,
  output logic               rd_en,
  output logic [IDX_W-1:0]   rd_idx,
  input  logic [nBits-1:0]   x_data,
  input  logic [nBits-1:0]   w_data,
  output logic [2:0]         alu_ctrl,
  output logic [nBits-1:0]   alu_a,
  output logic [nBits-1:0]   alu_b,
  input  logic [nBits-1:0]   alu_result,
  output logic               busy,
  output logic               done,
  output logic [nBits-1:0]   acc_out,
  output logic [nBits-1:0]   y
);

  localparam logic [IDX_W:0] N_MAX = (IDX_W+1)'(MAX_INPUTS);

  state_t             state_q, state_d;
  logic [IDX_W:0]     n_q, n_d;
  logic [nBits-1:0]   thr_q, thr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [nBits-1:0]   acc_q, acc_d;
  logic [nBits-1:0]   prod_q, prod_d;
  logic [nBits-1:0]   acc_out_q, acc_out_d;
  logic [nBits-1:0]   y_q, y_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      thr_q     <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      prod_q    <= '0;
      acc_out_q <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      thr_q     <= thr_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      prod_q    <= prod_d;
      acc_out_q <= acc_out_d;
      y_q       <= y_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    thr_d     = thr_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    acc_out_d = acc_out_q;
    y_d       = y_q;
    rd_en     = 1'b0;
    rd_idx    = '0;
    alu_ctrl  = ALU_PASS;
    alu_a     = '0;
    alu_b     = '0;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d     = (num_inputs > N_MAX) ? N_MAX : num_inputs;
          thr_d   = threshold;
          acc_d   = '0;
          idx_d   = '0;
          state_d = (num_inputs == '0) ? ST_ACT : ST_FETCH;
        end
      end
      ST_FETCH: begin
        rd_en   = 1'b1;
        rd_idx  = idx_q;
        state_d = ST_MUL;
      end
      ST_MUL: begin
        alu_ctrl = ALU_MUL;
        alu_a    = x_data;
        alu_b    = w_data;
        prod_d   = alu_result;
        state_d  = ST_ACC;
      end
      ST_ACC: begin
        alu_ctrl = ALU_ADD;
        alu_a    = acc_q;
        alu_b    = prod_q;
        acc_d    = alu_result;
        idx_d    = idx_q + 1'b1;
        // n_q is nonzero here: N = 0 bypasses the MAC loop entirely
        state_d  = ({1'b0, idx_q} == (n_q - 1'b1)) ? ST_ACT : ST_FETCH;
      end
      ST_ACT: begin
        alu_ctrl  = ALU_SGE;
        alu_a     = acc_q;
        alu_b     = thr_q;
        y_d       = alu_result;
        acc_out_d = acc_q;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign acc_out = acc_out_q;
  assign y       = y_q;

endmodule

`default_nettype wire

// File: tb/tb_neuron_alu_sequencer.sv
// tb_neuron_alu_sequencer: directed vectors with hand-computed results.
// Rev 1.0
`default_nettype none

module tb_neuron_alu_sequencer;
  import nn_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  num_inputs = '0;
  logic [31:0] threshold = '0;
  logic        rd_en;
  logic [3:0]  rd_idx;
  logic [31:0] x_data = '0;
  logic [31:0] w_data = '0;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        busy, done;
  logic [31:0] acc_out, y;

  logic [31:0] xmem [16];
  logic [31:0] wmem [16];

  int n_checks = 0;
  int n_errs   = 0;
  int r_done_cyc, r_busy, r_rd, r_dones;

  neuron_alu_sequencer #(.nBits(32), .MAX_INPUTS(16), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_inputs(num_inputs),
    .threshold(threshold), .rd_en(rd_en), .rd_idx(rd_idx),
    .x_data(x_data), .w_data(w_data), .alu_ctrl(alu_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .busy(busy), .done(done), .acc_out(acc_out), .y(y)
  );

  always #5 clk = ~clk;

  // Reference ALU sitting outside the sequencer
  always_comb begin
    case (alu_ctrl)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_MUL: alu_result = alu_a * alu_b;
      ALU_SGE: alu_result = {31'd0, (alu_a >= alu_b)};
      default: alu_result = alu_a;
    endcase
  end

  // One-cycle-latency operand memories
  always @(posedge clk) begin
    if (rd_en) begin
      x_data <= xmem[rd_idx];
      w_data <= wmem[rd_idx];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      xmem[i] = '0;
      wmem[i] = '0;
    end
  endtask

  // Starts a run in the next cycle (cycle 0) and follows it until done.
  // Optional start pulses are injected in cycles inj_a / inj_b.
  task automatic run_neuron(input logic [4:0] n, input logic [31:0] thr,
                            input int inj_a, input int inj_b);
    int cyc;
    @(negedge clk);
    start = 1'b1; num_inputs = n; threshold = thr;
    @(negedge clk);
    start = 1'b0; num_inputs = 5'd2; threshold = '1;
    cyc = 1; r_done_cyc = -1; r_busy = 0; r_rd = 0; r_dones = 0;
    while (r_done_cyc < 0 && cyc < 100) begin
      if (busy)  r_busy++;
      if (rd_en) r_rd++;
      if (done) begin
        r_dones++;
        r_done_cyc = cyc;
      end
      if (cyc == inj_a || cyc == inj_b) begin
        start = 1'b1; num_inputs = 5'd1; threshold = '0;
      end else begin
        start = 1'b0;
      end
      if (r_done_cyc < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    check_eq("done_seen", r_dones, 1);
  endtask

  initial begin
    int dones_in_reset;
    clear_mem();
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rd_en", rd_en, 0);
    check_eq("rst_ctrl", alu_ctrl, ALU_PASS);
    check_eq("rst_acc_out", acc_out, 0);
    check_eq("rst_y", y, 0);
    rst_n = 1'b1;

    // 1*4 + 2*5 + 3*6 = 32
    xmem[0] = 1; xmem[1] = 2; xmem[2] = 3;
    wmem[0] = 4; wmem[1] = 5; wmem[2] = 6;
    run_neuron(5'd3, 32'd30, -1, -1);
    check_eq("t1_acc", acc_out, 32'd32);
    check_eq("t1_y", y, 32'd1);
    check_eq("t1_done_cyc", r_done_cyc, 11);
    check_eq("t1_busy_cycles", r_busy, 11);
    check_eq("t1_reads", r_rd, 3);

    run_neuron(5'd3, 32'd33, -1, -1);
    check_eq("t2_acc", acc_out, 32'd32);
    check_eq("t2_y", y, 32'd0);
    check_eq("t2_done_cyc", r_done_cyc, 11);

    run_neuron(5'd0, 32'd0, -1, -1);
    check_eq("n0_acc", acc_out, 32'd0);
    check_eq("n0_y", y, 32'd1);
    check_eq("n0_done_cyc", r_done_cyc, 2);
    check_eq("n0_reads", r_rd, 0);
    check_eq("n0_busy_cycles", r_busy, 2);

    clear_mem();
    xmem[0] = 32'hFFFF_FFFF; wmem[0] = 32'd2;
    run_neuron(5'd1, 32'hFFFF_FFFF, -1, -1);
    check_eq("wrap_acc", acc_out, 32'hFFFF_FFFE);
    check_eq("wrap_y", y, 32'd0);
    check_eq("wrap_done_cyc", r_done_cyc, 5);

    // Clamp: N = 20 becomes 16; sum of (i+1) for i = 0..15 is 136
    for (int i = 0; i < 16; i++) begin
      xmem[i] = 32'd1;
      wmem[i] = 32'(i + 1);
    end
    run_neuron(5'd20, 32'd136, -1, -1);
    check_eq("clamp_acc", acc_out, 32'd136);
    check_eq("clamp_y", y, 32'd1);
    check_eq("clamp_done_cyc", r_done_cyc, 50);
    check_eq("clamp_reads", r_rd, 16);

    // Starts during busy (cycle 5) and in DONE (cycle 11) are ignored
    clear_mem();
    xmem[0] = 1; xmem[1] = 2; xmem[2] = 3;
    wmem[0] = 4; wmem[1] = 5; wmem[2] = 6;
    run_neuron(5'd3, 32'd30, 5, 11);
    check_eq("ign_acc", acc_out, 32'd32);
    check_eq("ign_y", y, 32'd1);
    check_eq("ign_done_cyc", r_done_cyc, 11);
    // Back-to-back start lands in cycle 3N+3 of the previous run
    run_neuron(5'd3, 32'd33, -1, -1);
    check_eq("b2b_y", y, 32'd0);
    check_eq("b2b_done_cyc", r_done_cyc, 11);

    // Restore a nonzero y/acc_out, then abort a run in cycle 4
    run_neuron(5'd3, 32'd30, -1, -1);
    @(negedge clk);
    start = 1'b1; num_inputs = 5'd3; threshold = 32'd30;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_rd_en", rd_en, 0);
    check_eq("abort_ctrl", alu_ctrl, ALU_PASS);
    check_eq("abort_alu_a", alu_a, 0);
    check_eq("abort_acc_out", acc_out, 0);
    check_eq("abort_y", y, 0);
    dones_in_reset = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones_in_reset++;
      if (i == 4) rst_n = 1'b1;
    end
    check_eq("abort_no_done", dones_in_reset, 0);
    run_neuron(5'd3, 32'd30, -1, -1);
    check_eq("post_rst_acc", acc_out, 32'd32);
    check_eq("post_rst_y", y, 32'd1);
    check_eq("post_rst_done_cyc", r_done_cyc, 11);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

`default_nettype wire
